// File: rtl/nsa_pkg.sv
// Shared nibble width and controller state encoding for the nibble-serial adder controller.
package nsa_pkg;

    localparam int unsigned NSA_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } nsa_state_t;

endpackage

// File: rtl/nsa_wait_cnt.sv
// Adder-latency wait counter; tc_c flags the cycle whose edge captures the adder result.
module nsa_wait_cnt #(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(LAT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == CNT_W'(LAT));

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Feeds operands one nibble at a time through an external registered 4-bit adder and
// reassembles the full sum. Define NSA_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int unsigned NIBBLES   = 4,
    parameter int unsigned ADDER_LAT = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NSA_NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NSA_NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                            in_cin,
    output logic [NSA_NIBBLE_W-1:0]         add_a,
    output logic [NSA_NIBBLE_W-1:0]         add_b,
    output logic                            add_cin,
    input  logic [NSA_NIBBLE_W-1:0]         add_sum,
    input  logic                            add_cout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NSA_NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                            out_cout
`ifdef NSA_OVF_EN
    ,
    output logic                            ovf
`endif
);

    localparam int unsigned W     = NSA_NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);

    nsa_state_t       state;
    nsa_state_t       state_d;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             tc_c;
    logic             accept_c;
    logic             capture_c;
    logic             last_c;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign last_c    = (idx == IDX_W'(NIBBLES - 1));
    assign idx_nxt   = idx + IDX_W'(1);

    nsa_wait_cnt #(
        .LAT (ADDER_LAT)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_c || capture_c),
        .en   (state == WAIT),
        .tc_c (tc_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (tc_c) begin
                    capture_c = 1'b1;
                    if (last_c) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Adder inputs only change on accept or capture, so they stay stable through each wait window.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef NSA_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (accept_c) begin
            a_q     <= in_a;
            b_q     <= in_b;
            idx     <= '0;
            add_a   <= in_a[NSA_NIBBLE_W-1:0];
            add_b   <= in_b[NSA_NIBBLE_W-1:0];
            add_cin <= in_cin;
        end else if (capture_c) begin
            out_sum[32'(idx)*NSA_NIBBLE_W +: NSA_NIBBLE_W] <= add_sum;
            if (!last_c) begin
                idx     <= idx_nxt;
                add_a   <= a_q[32'(idx_nxt)*NSA_NIBBLE_W +: NSA_NIBBLE_W];
                add_b   <= b_q[32'(idx_nxt)*NSA_NIBBLE_W +: NSA_NIBBLE_W];
                add_cin <= add_cout;
            end else begin
                out_cout <= add_cout;
`ifdef NSA_OVF_EN
                ovf      <= (a_q[W-1] == b_q[W-1]) && (add_sum[NSA_NIBBLE_W-1] != a_q[W-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl with a behavioural registered 4-bit adder stage.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned NIBBLES   = 4;
    localparam int unsigned ADDER_LAT = 2;
    localparam int unsigned W         = 4 * NIBBLES;
    localparam int unsigned LATENCY   = NIBBLES * (ADDER_LAT + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef NSA_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(
        .NIBBLES   (NIBBLES),
        .ADDER_LAT (ADDER_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef NSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Registered adder stage: result appears ADDER_LAT edges after it captures its inputs.
    logic [4:0] pipe [ADDER_LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= 5'(add_a) + 5'(add_b) + 5'(add_cin);
        for (int i = 1; i < ADDER_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_sum  = pipe[ADDER_LAT-1][3:0];
    assign add_cout = pipe[ADDER_LAT-1][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry into nibble n is the carry out of the low n nibbles of a + b + cin.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input int n);
        logic [W:0]   s;
        logic [W-1:0] m;
        if (n == 0) return cin;
        m = W'((33'd1 << (4 * n)) - 33'd1);
        s = (W+1)'(a & m) + (W+1)'(b & m) + (W+1)'(cin);
        return s[4*n];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
`ifdef NSA_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Issue one request, follow the adder bus nibble by nibble, and check the DONE result.
    task automatic run_to_done(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] es, input logic ec, input logic eo);
        int wait_cyc;
        int lat;
        int n;
        logic [3:0] ea;
        logic [3:0] eb;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 2 * LATENCY) begin
            n = lat / (ADDER_LAT + 1);
            if (n < NIBBLES) begin
                ea = a[4*n +: 4];
                eb = b[4*n +: 4];
                check("add_bus", 32'({add_a, add_b, add_cin}),
                      32'({ea, eb, carry_into(a, b, cin, n)}));
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        exp_sum  = es;
        exp_cout = ec;
        exp_ovf  = eo;
        check_outputs("done");
    endtask

    // Hold the result under backpressure, then complete the output handshake.
    task automatic finish_op(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check_outputs("hold");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        bit           spurious;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_ready_during_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_outputs("rst");

        foreach (vecs[i]) begin
            run_to_done(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            finish_op(1);
        end

        // Backpressure with a second request waiting at the source.
        run_to_done(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        in_a     = 16'h0F0F;
        in_b     = 16'h1010;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        finish_op(5);
        run_to_done(16'h0F0F, 16'h1010, 1'b1, 16'h1F20, 1'b0, 1'b0);
        finish_op(0);

        // Reset during nibble 2 discards the operation.
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_nibble2_a", 32'(add_a), 32'hA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_outputs("midrst");
        spurious = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        check("midrst_no_output", 32'(spurious), 32'd0);
        run_to_done(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        finish_op(0);

        // Random operands against plain full-width arithmetic.
        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_to_done(ra, rb, rc, full[W-1:0], full[W],
                        (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]));
            finish_op(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
- REQ-001 Parameter NIBBLES, default 4: operand width is 4*NIBBLES bits; legal range 2..8.
- REQ-002 Parameter ADDER_LAT, default 2: clock edges from the 4-bit adder stage capturing an operand to a valid add_sum/add_cout; legal range 1..4.
- REQ-003 Ports:
  - clk  in  1  rising-edge clock.
  - rst  in  1  reset; one clock; reset is synchronous and active-high.
  - in_valid  in  1  operand request.
  - in_ready  out  1  block can accept an operand request.
  - in_a  in  4*NIBBLES  operand A.
  - in_b  in  4*NIBBLES  operand B.
  - in_cin  in  1  carry-in.
  - add_a  out  4  nibble to adder A_in.
  - add_b  out  4  nibble to adder B_in.
  - add_cin  out  1  carry to adder Cin.
  - add_sum  in  4  adder sum.
  - add_cout  in  1  adder Cout.
  - out_valid  out  1  result available.
  - out_ready  in  1  consumer accepts the result.
  - out_sum  out  4*NIBBLES  full-width sum.
  - out_cout  out  1  final carry-out.
  - ovf  out  1  signed overflow; present only with NSA_OVF_EN.

Function
- REQ-004 States: IDLE, WAIT, DONE.
- REQ-005 in_ready SHALL be 1 only in IDLE with rst low.
- REQ-006 Accept on an edge with in_valid & in_ready:
  - latch in_a, in_b;
  - nibble index := 0;
  - load add_a/add_b := nibble 0, add_cin := in_cin;
  - wait counter := 0;
  - go WAIT.
- REQ-007 add_a, add_b, add_cin SHALL be registered and held stable for the whole WAIT period of each nibble.
- REQ-008 In WAIT the counter SHALL increment every cycle. On the (ADDER_LAT+1)th edge after add_* were loaded, the block SHALL:
  - capture add_sum into out_sum nibble [index];
  - set running carry := add_cout.
- REQ-009 On that same capture edge:
  - if index < NIBBLES-1: index += 1, load the next nibbles and add_cin := add_cout, counter := 0, stay in WAIT;
  - otherwise: out_cout := add_cout, go DONE.
- REQ-010 out_valid SHALL be 1 exactly in DONE. It first rises NIBBLES*(ADDER_LAT+1) edges after the accept edge (12 edges at default parameters).
- REQ-011 In DONE, out_sum, out_cout and ovf SHALL hold stable until an edge with out_ready=1. That edge SHALL return the block to IDLE.
- REQ-012 There is no pipelining: in_valid outside IDLE SHALL be ignored, and the request stays pending at the source.
- REQ-013 out_sum SHALL equal (in_a + in_b + in_cin) mod 2^(4*NIBBLES), and out_cout SHALL equal bit 4*NIBBLES of that sum.
- REQ-014 add_sum and add_cout SHALL be ignored on every edge other than the capture edges.

Reset
- REQ-015 An edge with rst=1 SHALL, from any state including mid-WAIT:
  - set state := IDLE;
  - clear index and counter to 0;
  - clear add_a, add_b, add_cin, out_sum, out_cout and ovf to 0;
  - deassert out_valid.
- REQ-016 Any in-flight operation SHALL be discarded without output. in_ready SHALL be 1 on the first cycle after rst falls.

Configuration
- REQ-017 Macro NSA_OVF_EN:
  - defined: port ovf exists and is set on the final capture edge to (A msb == B msb) & (out_sum msb != A msb);
  - undefined: port ovf and its logic are absent, and all other behaviour is identical.

Structure
- REQ-018 Package nsa_pkg SHALL hold:
  - NSA_NIBBLE_W = 4;
  - the state enum nsa_state_t {IDLE, WAIT, DONE}.
- REQ-019 The wait counter with terminal-count detect SHALL be the single sub-module nsa_wait_cnt. All other logic SHALL live in the top module.
- REQ-020 The bench SHALL connect add_* to the existing 4-bit registered CLA adder stage using the same clk.

Verification (NIBBLES=4, ADDER_LAT=2, NSA_OVF_EN defined)
- REQ-021 A=0x00FF, B=0x0001, cin=0 -> out_sum=0x0100, out_cout=0, ovf=0; out_valid rises 12 edges after accept.
- REQ-022 A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1, ovf=0.
- REQ-023 A=0x7FFF, B=0x0001 -> out_sum=0x8000, out_cout=0, ovf=1.
- REQ-024 A=B=0x0000, cin=1 -> out_sum=0x0001. add_cin SHALL be 1,0,0,0 across nibbles 0..3, and add_a/add_b SHALL hold for 3 cycles each.
- REQ-025 Backpressure: hold out_ready=0 for 5 cycles in DONE with a second in_valid pending -> out_sum, out_cout and ovf stable, in_ready=0, second request accepted only after the out_ready handshake.
- REQ-026 Reset mid-op: rst=1 for one edge during nibble 2 -> next cycle out_valid=0, in_ready=1, add_*=0; a following 0x1234+0x4321 gives 0x5555, out_cout=0.
